blink_arbiter: RTL



---
 rtl/blink_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/blink_arbiter.sv
// blink_arbiter
//   Shares one LED blink datapath (phase counter + LED register) between
//   NREQ requesters. A winner is picked in IDLE, then the block runs its
//   requested number of ON/OFF blinks and pulses done[winner] for one cycle.
//
//   Build option: BLINK_ARB_FIXED_PRIO_EN
//     defined   -> fixed priority, lowest asserted index wins, no pointer
//     undefined -> round-robin starting from a rotating pointer (default)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   req          per-requester request level, held until done or abort
//   blinks       packed blink counts, field i = [i*BLINK_W +: BLINK_W]
//   half_period  phase length minus one, latched at grant
//   gnt          one-hot grant (registered)
//   done         one-cycle completion pulse (registered)
//   busy         high while a grant is held
//   led          registered LED drive
module blink_arbiter #(
  parameter int NREQ    = 4,
  parameter int CNT_W   = 8,
  parameter int BLINK_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*BLINK_W-1:0]   blinks,
  input  logic [CNT_W-1:0]          half_period,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           done,
  output logic                      busy,
  output logic                      led
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   hp;
  logic [BLINK_W-1:0] rem;
  logic [IW-1:0]      win;

  logic               any_req;
  logic [IW-1:0]      pick;
  logic [BLINK_W-1:0] pick_bl;

`ifndef BLINK_ARB_FIXED_PRIO_EN
  logic [IW-1:0] ptr;

  // Index after w, wrapping at NREQ (NREQ need not be a power of two).
  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] w);
    return (int'(w) == NREQ - 1) ? '0 : w + 1'b1;
  endfunction
`endif

  // Winner selection.
  always_comb begin
    any_req = |req;
    pick    = '0;
`ifdef BLINK_ARB_FIXED_PRIO_EN
    // Downward scan so the lowest asserted index is the last write.
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[i]) pick = IW'(i);
`else
    begin
      logic found;
      int   idx;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr) + k) % NREQ;
        if (!found && req[idx]) begin
          found = 1'b1;
          pick  = IW'(idx);
        end
      end
    end
`endif
  end

  assign pick_bl = blinks[int'(pick)*BLINK_W +: BLINK_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      gnt   <= '0;
      done  <= '0;
      busy  <= 1'b0;
      led   <= 1'b0;
      cnt   <= '0;
      hp    <= '0;
      rem   <= '0;
      win   <= '0;
`ifndef BLINK_ARB_FIXED_PRIO_EN
      ptr   <= '0;
`endif
    end else begin
      done <= '0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            win <= pick;
            hp  <= half_period;
            cnt <= '0;
            rem <= pick_bl;
            if (pick_bl != '0) begin
              gnt   <= NREQ'(1) << pick;
              busy  <= 1'b1;
              led   <= 1'b1;
              state <= S_ON;
            end else begin
              // Nothing to blink: acknowledge immediately, no grant.
              done <= NREQ'(1) << pick;
`ifndef BLINK_ARB_FIXED_PRIO_EN
              ptr  <= nxt(pick);
`endif
            end
          end
        end

        S_ON, S_OFF: begin
          if (!req[win]) begin
            // Requester withdrew: drop service silently.
            state <= S_IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            led   <= 1'b0;
            cnt   <= '0;
`ifndef BLINK_ARB_FIXED_PRIO_EN
            ptr   <= nxt(win);
`endif
          end else if (cnt != hp) begin
            cnt <= cnt + 1'b1;
          end else if (state == S_ON) begin
            cnt   <= '0;
            led   <= 1'b0;
            state <= S_OFF;
          end else begin
            cnt <= '0;
            rem <= rem - 1'b1;
            if (rem == BLINK_W'(1)) begin
              state <= S_IDLE;
              gnt   <= '0;
              busy  <= 1'b0;
              done  <= NREQ'(1) << win;
`ifndef BLINK_ARB_FIXED_PRIO_EN
              ptr   <= nxt(win);
`endif
            end else begin
              led   <= 1'b1;
              state <= S_ON;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
